// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined chunk adder: op encoding and
// helpers for splitting the operand width into per-stage chunks.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int chunk_width(input int w, input int s);
        return w / s;
    endfunction

    function automatic bit split_ok(input int w, input int s);
        return (s >= 1) && ((w % s) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple of full-adder cells.
// Ports: a, b, cin in; sum, cout out.
module adder_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] c;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[W];

endmodule

// File: rtl/pipelined_chunk_adder.sv
// Pipelined add/subtract: one CHUNK-bit slice resolves per stage, carry
// rides the pipeline registers; valid/ready with full backpressure.
// Ports: clk, rst (async, active-high); in_valid/in_ready, in1, in2, cin,
// sub; out_valid/out_ready, sum, cout, ovf.
// Optional: PIPELINED_CHUNK_ADDER_SAT_EN adds input sat, which clamps
// sum on signed overflow.
module pipelined_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             sub,
`ifdef PIPELINED_CHUNK_ADDER_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int C = chunk_width(WIDTH, STAGES);

    if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
        $error("WIDTH must be a non-zero multiple of STAGES");
    end

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             sat;
    } stg_t;

    stg_t                  src [STAGES];
    stg_t                  nxt [STAGES];
    stg_t                  q   [STAGES];
    logic [STAGES-1:0]     v;
    logic [STAGES-1:0]     vin;
    logic [STAGES-1:0]     rdy;
    logic [STAGES-1:0][C-1:0] cs;
    logic [STAGES-1:0]     co;
    logic                  rst_done;
    logic                  sat_in;

`ifdef PIPELINED_CHUNK_ADDER_SAT_EN
    assign sat_in = sat;
`else
    assign sat_in = 1'b0;
`endif

    // Keeps in_ready low until the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_done <= 1'b0;
        else     rst_done <= 1'b1;
    end

    // Stage k can move when empty or when everything downstream can move.
    always_comb begin
        logic r;
        r = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r      = ~v[k] | r;
            rdy[k] = r;
        end
        rdy[0] = rdy[0] & rst_done;
    end

    assign in_ready = rdy[0];

    always_comb begin
        vin[0]     = in_valid;
        src[0]     = '0;
        src[0].a   = in1;
        src[0].b   = (sub == OP_ADD) ? in2 : ~in2;
        src[0].c   = cin ^ (sub == OP_SUB);
        src[0].sat = sat_in;
        for (int k = 1; k < STAGES; k++) begin
            vin[k] = v[k-1];
            src[k] = q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_chunk #(.W(C)) u_chunk (
            .a    (src[k].a[k*C +: C]),
            .b    (src[k].b[k*C +: C]),
            .cin  (src[k].c),
            .sum  (cs[k]),
            .cout (co[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt[k]             = src[k];
            nxt[k].s[k*C +: C] = cs[k];
            nxt[k].c           = co[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int k = 0; k < STAGES; k++) q[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) v[k] <= vin[k];
                if (rdy[k] && vin[k]) q[k] <= nxt[k];
            end
        end
    end

    logic ovf_w;

    assign out_valid = v[STAGES-1];
    assign cout      = q[STAGES-1].c;
    assign ovf_w     = (q[STAGES-1].a[WIDTH-1] == q[STAGES-1].b[WIDTH-1])
                     & (q[STAGES-1].s[WIDTH-1] != q[STAGES-1].a[WIDTH-1]);
    assign ovf       = ovf_w;

`ifdef PIPELINED_CHUNK_ADDER_SAT_EN
    always_comb begin
        sum = q[STAGES-1].s;
        if (q[STAGES-1].sat && ovf_w) begin
            sum            = {WIDTH{~q[STAGES-1].a[WIDTH-1]}};
            sum[WIDTH-1]   = q[STAGES-1].a[WIDTH-1];
        end
    end
`else
    assign sum = q[STAGES-1].s;
`endif

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Directed self-checking bench for pipelined_chunk_adder: a 32/4 instance
// and an 8/1 instance, hand-computed vectors plus an in-order stream.
module tb_pipelined_chunk_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        sat = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [7:0]  b_in1 = '0;
    logic [7:0]  b_in2 = '0;
    logic        b_cin = 1'b0;
    logic        b_sub = 1'b0;
    logic        b_sat = 1'b0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [7:0]  b_sum;
    logic        b_cout;
    logic        b_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipelined_chunk_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .sub       (sub),
`ifdef PIPELINED_CHUNK_ADDER_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    pipelined_chunk_adder #(.WIDTH(8), .STAGES(1)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in1       (b_in1),
        .in2       (b_in2),
        .cin       (b_cin),
        .sub       (b_sub),
`ifdef PIPELINED_CHUNK_ADDER_SAT_EN
        .sat       (b_sat),
`endif
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .sum       (b_sum),
        .cout      (b_cout),
        .ovf       (b_ovf)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum}
    function automatic logic [33:0] model(input logic [31:0] a,
        input logic [31:0] b, input logic ci, input logic s);
        logic [31:0] be;
        logic [32:0] r;
        logic        o;
        be = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, be} + {32'd0, ci ^ s};
        o  = (a[31] == be[31]) && (r[31] != a[31]);
        return {o, r};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a,
        input logic [31:0] b, input logic c, input logic s, input logic st,
        input logic [31:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        in1 = a; in2 = b; cin = c; sub = s; sat = st;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, "_lat"}, n, 4);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, ovf, eo);
    endtask

    logic [31:0] ta [8] = '{32'h00000001, 32'h7FFFFFFF, 32'h12345678,
                            32'h80000000, 32'hDEADBEEF, 32'h00000000,
                            32'hFFFF0000, 32'h55555555};
    logic [31:0] tb_ [8] = '{32'h00000002, 32'h00000001, 32'h11111111,
                             32'h00000001, 32'hDEADBEEF, 32'h00000001,
                             32'h0000FFFF, 32'hAAAAAAAA};
    logic        tc [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        ts [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    logic [7:0] ba [3] = '{8'hC8, 8'h01, 8'h7F};
    logic [7:0] bb [3] = '{8'h64, 8'h02, 8'h01};
    logic [7:0] bs [3] = '{8'h2C, 8'h03, 8'h80};
    logic       bc [3] = '{1'b1, 1'b0, 1'b0};
    logic       bo [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] qexp[$];
        logic [33:0] e;
        logic [31:0] hold_s;
        logic        held;
        int sent, rcvd, infl;
        logic acc_in, acc_out;

        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_in_ready_pre", in_ready, 0);
        @(posedge clk);
        #1;
        check("rel_in_ready_post", in_ready, 1);

        run_op("add_wrap", 32'hFFFFFFFF, 32'h1, 0, 0, 0, 32'h0, 1, 0);
        run_op("sub_min", 32'h80000000, 32'h1, 0, 1, 0, 32'h7FFFFFFF, 1, 1);
        run_op("sub_neg", 32'h5, 32'h7, 0, 1, 0, 32'hFFFFFFFE, 0, 0);
`ifdef PIPELINED_CHUNK_ADDER_SAT_EN
        run_op("sat_pos", 32'h7FFFFFFF, 32'h1, 0, 0, 1, 32'h7FFFFFFF, 0, 1);
        run_op("sat_neg", 32'h80000000, 32'h1, 0, 1, 1, 32'h80000000, 1, 1);
        run_op("wrap_pos", 32'h7FFFFFFF, 32'h1, 0, 0, 0, 32'h80000000, 0, 1);
        run_op("wrap_neg", 32'h80000000, 32'h1, 0, 1, 0, 32'h7FFFFFFF, 1, 1);
`endif

        @(negedge clk);
        sent = 0; rcvd = 0; infl = 0; held = 1'b0; hold_s = '0;
        for (int c = 0; c < 60 && rcvd < 8; c++) begin
            @(negedge clk);
            if (held) begin
                check("stall_valid", out_valid, 1);
                check("stall_sum", sum, hold_s);
            end
            out_ready = !(c >= 3 && c <= 6);
            in_valid = (sent < 8);
            if (sent < 8) begin
                in1 = ta[sent]; in2 = tb_[sent];
                cin = tc[sent]; sub = ts[sent]; sat = 1'b0;
            end
            #1;
            check("in_ready", in_ready, (infl < 4) || out_ready);
            if (c == 4) check("full_stall", in_ready, 0);
            acc_in  = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (acc_out) begin
                if (qexp.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = qexp.pop_front();
                    check("stream_sum", sum, e[31:0]);
                    check("stream_cout", cout, e[32]);
                    check("stream_ovf", ovf, e[33]);
                end
                rcvd++;
            end
            held   = out_valid && !out_ready;
            hold_s = sum;
            if (acc_in) begin
                qexp.push_back(model(ta[sent], tb_[sent], tc[sent], ts[sent]));
                sent++;
            end
            infl = infl + int'(acc_in) - int'(acc_out);
        end
        in_valid = 1'b0;
        check("stream_count", rcvd, 8);
        out_ready = 1'b1;

        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in1 = 32'(i + 1); in2 = 32'h10; cin = 0; sub = 0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_sum", sum, 32'h11);
        #2 rst = 1'b1;
        #1;
        check("async_valid", out_valid, 0);
        check("async_sum", sum, 0);
        check("async_cout", cout, 0);
        check("async_ovf", ovf, 0);
        check("async_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_valid", out_valid, 0);
            check("post_rst_sum", sum, 0);
        end

        @(negedge clk);
        b_out_ready = 1'b1;
        b_in_valid = 1'b1;
        b_in1 = ba[0]; b_in2 = bb[0];
        for (int i = 0; i < 3; i++) begin
            #1;
            check("b_in_ready", b_in_ready, 1);
            @(negedge clk);
            check("b_valid", b_out_valid, 1);
            check("b_sum", b_sum, bs[i]);
            check("b_cout", b_cout, bc[i]);
            check("b_ovf", b_ovf, bo[i]);
            if (i < 2) begin
                b_in1 = ba[i+1]; b_in2 = bb[i+1];
            end else begin
                b_in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("b_drained", b_out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
